// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: ALUOp, funct codes, internal ALU
// control codes and MEM control bit positions.
package mips_pkg;

   localparam int WB_CTL_W  = 2;
   localparam int M_CTL_W   = 3;
   localparam int ALU_OP_W  = 2;
   localparam int FUNCT_W   = 6;
   localparam int ALUCTL_W  = 4;

   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [ALU_OP_W-1:0] ALU_OP_RSVD  = 2'b11;

   localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
   localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
   localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
   localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
   localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'h27;
   localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

   localparam logic [ALUCTL_W-1:0] ALUCTL_AND = 4'd0;
   localparam logic [ALUCTL_W-1:0] ALUCTL_OR  = 4'd1;
   localparam logic [ALUCTL_W-1:0] ALUCTL_ADD = 4'd2;
   localparam logic [ALUCTL_W-1:0] ALUCTL_SUB = 4'd6;
   localparam logic [ALUCTL_W-1:0] ALUCTL_SLT = 4'd7;
   localparam logic [ALUCTL_W-1:0] ALUCTL_NOR = 4'd12;

   // m_ctl = {branch, mem_read, mem_write}
   localparam int M_CTL_BRANCH    = 2;
   localparam int M_CTL_MEM_READ  = 1;
   localparam int M_CTL_MEM_WRITE = 0;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the EX stage: add/sub/and/or/nor/slt with zero and
// signed-overflow flags.
module ex_alu
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [ALUCTL_W-1:0] alu_ctl_i,
   input  logic [DATA_W-1:0]   a_i,
   input  logic [DATA_W-1:0]   b_i,
   output logic [DATA_W-1:0]   result_o,
   output logic                zero_o,
   output logic                overflow_o
);

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;
   logic              sum_ovf;
   logic              diff_ovf;
   logic              lt;

   assign sum  = a_i + b_i;
   assign diff = a_i - b_i;

   // Same-sign operands producing an opposite-sign sum overflow; for sub the
   // operands must differ in sign.
   assign sum_ovf  = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1]  != a_i[DATA_W-1]);
   assign diff_ovf = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);
   assign lt       = $signed(a_i) < $signed(b_i);

   always_comb begin
      result_o   = sum;
      overflow_o = sum_ovf;
      case (alu_ctl_i)
         ALUCTL_SUB: begin
            result_o   = diff;
            overflow_o = diff_ovf;
         end
         ALUCTL_AND: begin
            result_o   = a_i & b_i;
            overflow_o = 1'b0;
         end
         ALUCTL_OR: begin
            result_o   = a_i | b_i;
            overflow_o = 1'b0;
         end
         ALUCTL_NOR: begin
            result_o   = ~(a_i | b_i);
            overflow_o = 1'b0;
         end
         ALUCTL_SLT: begin
            result_o   = {{(DATA_W-1){1'b0}}, lt};
            overflow_o = 1'b0;
         end
         default: begin
            result_o   = sum;
            overflow_o = sum_ovf;
         end
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control decode, operand muxing, ALU, branch-target
// adder and the EX/MEM pipeline latch with stall/flush/valid handling.
module ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [WB_CTL_W-1:0]   wb_ctl,
   input  logic [M_CTL_W-1:0]    m_ctl,
   input  logic                  reg_dest,
   input  logic                  alu_src,
   input  logic [ALU_OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0]     npc,
   input  logic [DATA_W-1:0]     r_data_1,
   input  logic [DATA_W-1:0]     r_data_2,
   input  logic [DATA_W-1:0]     sign_extend,
   input  logic [REG_ADDR_W-1:0] instr_2016,
   input  logic [REG_ADDR_W-1:0] instr_1511,
   output logic                  valid_out,
   output logic [WB_CTL_W-1:0]   wb_ctl_out,
   output logic [M_CTL_W-1:0]    m_ctl_out,
   output logic [DATA_W-1:0]     add_result,
   output logic                  zero,
   output logic                  overflow,
   output logic [DATA_W-1:0]     alu_result,
   output logic [DATA_W-1:0]     r_data_2_out,
   output logic [REG_ADDR_W-1:0] write_reg
);

   typedef struct packed {
      logic                  valid;
      logic [WB_CTL_W-1:0]   wb_ctl;
      logic [M_CTL_W-1:0]    m_ctl;
      logic [DATA_W-1:0]     add_result;
      logic                  zero;
      logic                  overflow;
      logic [DATA_W-1:0]     alu_result;
      logic [DATA_W-1:0]     r_data_2;
      logic [REG_ADDR_W-1:0] write_reg;
   } ex_mem_t;

   logic [FUNCT_W-1:0]  funct;
   logic [ALUCTL_W-1:0] alu_ctl;
   logic [DATA_W-1:0]   alu_b;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_zero;
   logic                alu_ovf;
   logic [DATA_W-1:0]   br_target;
   ex_mem_t             load;
   ex_mem_t             ex_mem_d;
   ex_mem_t             ex_mem_q;

   assign funct = sign_extend[FUNCT_W-1:0];

   // Unknown funct codes and the reserved ALUOp fall back to add.
   always_comb begin
      alu_ctl = ALUCTL_ADD;
      case (alu_op)
         ALU_OP_ADD: alu_ctl = ALUCTL_ADD;
         ALU_OP_SUB: alu_ctl = ALUCTL_SUB;
         ALU_OP_FUNCT: begin
            case (funct)
               FUNCT_ADD: alu_ctl = ALUCTL_ADD;
               FUNCT_SUB: alu_ctl = ALUCTL_SUB;
               FUNCT_AND: alu_ctl = ALUCTL_AND;
               FUNCT_OR:  alu_ctl = ALUCTL_OR;
               FUNCT_NOR: alu_ctl = ALUCTL_NOR;
               FUNCT_SLT: alu_ctl = ALUCTL_SLT;
               default:   alu_ctl = ALUCTL_ADD;
            endcase
         end
         default: alu_ctl = ALUCTL_ADD;
      endcase
   end

   assign alu_b     = alu_src ? sign_extend : r_data_2;
   assign br_target = npc + {sign_extend[DATA_W-3:0], 2'b00};

   ex_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .alu_ctl_i  (alu_ctl),
      .a_i        (r_data_1),
      .b_i        (alu_b),
      .result_o   (alu_res),
      .zero_o     (alu_zero),
      .overflow_o (alu_ovf)
   );

   always_comb begin
      load.valid      = 1'b1;
      load.wb_ctl     = wb_ctl;
      load.m_ctl      = m_ctl;
      load.add_result = br_target;
      load.zero       = alu_zero;
      load.overflow   = alu_ovf;
      load.alu_result = alu_res;
      load.r_data_2   = r_data_2;
      load.write_reg  = reg_dest ? instr_1511 : instr_2016;
   end

   // flush beats stall; an empty ID/EX slot loads a bubble.
   always_comb begin
      ex_mem_d = '0;
      if (flush)
         ex_mem_d = '0;
      else if (stall)
         ex_mem_d = ex_mem_q;
      else if (in_valid)
         ex_mem_d = load;
   end

   always_ff @(posedge clk) begin
      if (rst)
         ex_mem_q <= '0;
      else
         ex_mem_q <= ex_mem_d;
   end

   assign valid_out    = ex_mem_q.valid;
   assign wb_ctl_out   = ex_mem_q.wb_ctl;
   assign m_ctl_out    = ex_mem_q.m_ctl;
   assign add_result   = ex_mem_q.add_result;
   assign zero         = ex_mem_q.zero;
   assign overflow     = ex_mem_q.overflow;
   assign alu_result   = ex_mem_q.alu_result;
   assign r_data_2_out = ex_mem_q.r_data_2;
   assign write_reg    = ex_mem_q.write_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed cases plus randomized traffic
// against an arithmetic reference model of the EX/MEM latch.
module tb_ex_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct packed {
      logic          valid;
      logic [1:0]    wb;
      logic [2:0]    m;
      logic [DW-1:0] add_result;
      logic          zero;
      logic          ovf;
      logic [DW-1:0] alu;
      logic [DW-1:0] rd2;
      logic [AW-1:0] wreg;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst, stall, flush, in_valid, reg_dest, alu_src;
   logic [1:0]    wb_ctl, alu_op;
   logic [2:0]    m_ctl;
   logic [DW-1:0] npc, r_data_1, r_data_2, sign_extend;
   logic [AW-1:0] instr_2016, instr_1511;
   logic          valid_out, zero, overflow;
   logic [1:0]    wb_ctl_out;
   logic [2:0]    m_ctl_out;
   logic [DW-1:0] add_result, alu_result, r_data_2_out;
   logic [AW-1:0] write_reg;

   exp_t  model;
   exp_t  eq[$];
   string nq[$];
   int    pass_cnt = 0;
   int    tot_cnt  = 0;

   always #5 clk = ~clk;

   ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .wb_ctl(wb_ctl), .m_ctl(m_ctl), .reg_dest(reg_dest), .alu_src(alu_src),
      .alu_op(alu_op), .npc(npc), .r_data_1(r_data_1), .r_data_2(r_data_2),
      .sign_extend(sign_extend), .instr_2016(instr_2016), .instr_1511(instr_1511),
      .valid_out(valid_out), .wb_ctl_out(wb_ctl_out), .m_ctl_out(m_ctl_out),
      .add_result(add_result), .zero(zero), .overflow(overflow),
      .alu_result(alu_result), .r_data_2_out(r_data_2_out), .write_reg(write_reg)
   );

   // Reference: interpret the instruction with wide signed arithmetic.
   function automatic exp_t calc();
      exp_t   e;
      longint sa, sb, s;
      logic [DW-1:0] b, res;
      int     op;  // 0 add 1 sub 2 and 3 or 4 nor 5 slt
      b  = alu_src ? sign_extend : r_data_2;
      sa = longint'($signed(r_data_1));
      sb = longint'($signed(b));
      op = 0;
      if (alu_op == 2'b01) op = 1;
      else if (alu_op == 2'b10) begin
         case (sign_extend[5:0])
            6'h22: op = 1;
            6'h24: op = 2;
            6'h25: op = 3;
            6'h27: op = 4;
            6'h2A: op = 5;
            default: op = 0;
         endcase
      end
      e = '0;
      case (op)
         0: begin s = sa + sb; res = s[DW-1:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         1: begin s = sa - sb; res = s[DW-1:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         2: res = r_data_1 & b;
         3: res = r_data_1 | b;
         4: res = ~(r_data_1 | b);
         default: res = (sa < sb) ? 32'd1 : 32'd0;
      endcase
      s = longint'({32'd0, npc}) + longint'({32'd0, sign_extend}) * 4;
      e.valid      = 1'b1;
      e.wb         = wb_ctl;
      e.m          = m_ctl;
      e.add_result = s[DW-1:0];
      e.zero       = (res == 0);
      e.alu        = res;
      e.rd2        = r_data_2;
      e.wreg       = reg_dest ? instr_1511 : instr_2016;
      return e;
   endfunction

   task automatic cyc(input string nm);
      if (rst || flush)  model = '0;
      else if (stall)    model = model;
      else if (in_valid) model = calc();
      else               model = '0;
      eq.push_back(model);
      nq.push_back(nm);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      tot_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got=%h exp=%h", nm, got, exp);
   endtask

   function automatic logic [DW-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic rnd_inputs();
      logic [5:0] fl[7];
      fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25;
      fl[4] = 6'h27; fl[5] = 6'h2A; fl[6] = 6'($urandom);
      wb_ctl      = 2'($urandom);
      m_ctl       = 3'($urandom);
      reg_dest    = 1'($urandom);
      alu_src     = 1'($urandom);
      alu_op      = 2'($urandom);
      npc         = $urandom;
      r_data_1    = pick_operand();
      r_data_2    = ($urandom_range(0, 3) == 0) ? r_data_1 : pick_operand();
      sign_extend = pick_operand();
      sign_extend[5:0] = fl[$urandom_range(0, 6)];
      instr_2016  = 5'($urandom);
      instr_1511  = 5'($urandom);
   endtask

   // Monitor: the latch presents a new slot every edge; compare each one.
   always @(posedge clk) begin
      exp_t  got, e;
      string nm;
      #1;
      if (eq.size() > 0) begin
         e  = eq.pop_front();
         nm = nq.pop_front();
         got = {valid_out, wb_ctl_out, m_ctl_out, add_result, zero, overflow,
                alu_result, r_data_2_out, write_reg};
         tot_cnt++;
         if (got === e) pass_cnt++;
         else $display("FAIL %s got=%h exp=%h", nm, got, e);
      end
   end

   initial begin
      rst = 0; stall = 0; flush = 0; in_valid = 0;
      rnd_inputs();
      model = '0;
      @(negedge clk);

      // reset with live inputs
      rst = 1; in_valid = 1; rnd_inputs();
      cyc("rst0"); rnd_inputs(); cyc("rst1");
      chk("rst_valid", {31'd0, valid_out}, 0);
      chk("rst_alu", alu_result, 0);
      chk("rst_addr", add_result, 0);
      rst = 0;

      // R-type add
      alu_op = 2'b10; sign_extend = 32'h20; r_data_1 = 5; r_data_2 = 7;
      alu_src = 0; reg_dest = 1; instr_1511 = 3; in_valid = 1;
      cyc("radd");
      chk("radd_res", alu_result, 12);
      chk("radd_wreg", {27'd0, write_reg}, 3);
      chk("radd_zero_valid", {30'd0, zero, valid_out}, 32'd1);

      // beq
      alu_op = 2'b01; r_data_1 = 32'h1234; r_data_2 = 32'h1234; npc = 32'h100;
      sign_extend = 4; m_ctl = 3'b100;
      cyc("beq");
      chk("beq_zero", {31'd0, zero}, 1);
      chk("beq_target", add_result, 32'h110);
      chk("beq_mctl", {29'd0, m_ctl_out}, 32'h4);

      // signed cases
      alu_op = 2'b10; sign_extend = 32'h2A; r_data_1 = 32'hFFFF_FFFF; r_data_2 = 1;
      cyc("slt");
      chk("slt_res", alu_result, 1);
      alu_op = 2'b00; r_data_1 = 32'h7FFF_FFFF; r_data_2 = 1;
      cyc("addovf");
      chk("addovf_res", alu_result, 32'h8000_0000);
      chk("addovf_flag", {31'd0, overflow}, 1);
      alu_src = 1; sign_extend = 32'hFFFF_FFFC; r_data_1 = 32'h10;
      reg_dest = 0; instr_2016 = 5'd9; instr_1511 = 5'd17;
      cyc("lw");
      chk("lw_res", alu_result, 32'hC);
      chk("lw_wreg", {27'd0, write_reg}, 9);

      // stall holds, then stall+flush bubbles
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         rnd_inputs(); cyc("stall");
         chk("stall_hold", alu_result, 32'hC);
      end
      flush = 1; rnd_inputs();
      cyc("stall_flush");
      chk("sf_ctl", {27'd0, valid_out, wb_ctl_out, m_ctl_out}, 0);
      stall = 0; flush = 0;

      // reset mid-stream, then a normal load
      rnd_inputs(); cyc("pre_rst");
      rst = 1; rnd_inputs(); cyc("mid_rst");
      chk("mid_rst_valid", {31'd0, valid_out}, 0);
      rst = 0; alu_op = 2'b00; alu_src = 0; r_data_1 = 100; r_data_2 = 23;
      cyc("post_rst");
      chk("post_rst_res", alu_result, 123);
      chk("post_rst_valid", {31'd0, valid_out}, 1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rnd_inputs();
         rst      = ($urandom_range(0, 49) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         stall    = ($urandom_range(0, 5) == 0);
         in_valid = ($urandom_range(0, 4) != 0);
         cyc("rand");
      end
      rst = 0; flush = 0; stall = 0; in_valid = 0;

      repeat (3) @(negedge clk);
      tot_cnt++;
      if (eq.size() == 0) pass_cnt++;
      else $display("FAIL drain left=%0d exp=0", eq.size());

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
